// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I control unit: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and issues datapath enables per state.
module control_unit_mc #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int ALU_CTRL_W  = 4,
    parameter int RFWD_SEL_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instrCode,
    input  logic                  busReady,
    output logic                  pcEn,
    output logic                  irWe,
    output logic                  regFileWe,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  aluSrcMuxSel,
    output logic                  busReq,
    output logic                  busWe,
    output logic [RFWD_SEL_W-1:0] RFWDSrcMuxSel,
    output logic                  branch,
    output logic                  jal,
    output logic                  jalr,
    output logic                  illegal
);

    localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
    localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SRAI = 4'b1101;

    localparam logic [2:0] RFWD_ALU   = 3'd0;
    localparam logic [2:0] RFWD_LOAD  = 3'd1;
    localparam logic [2:0] RFWD_LUI   = 3'd2;
    localparam logic [2:0] RFWD_AUIPC = 3'd3;
    localparam logic [2:0] RFWD_PC4   = 3'd4;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_L, CL_S, CL_B, CL_LU, CL_AU, CL_J, CL_JL, CL_ILL
    } instr_class_e;

    state_e       state_q, state_d;
    instr_class_e cls;
    logic [3:0]   alu_op;
    logic         src_op;
    logic [2:0]   rfwd_op;
    logic         mem_done;
    logic         unused_instr_bits;

    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // With waiting disabled the data memory always answers in one cycle.
    assign mem_done = busReady || !MEM_WAIT_EN;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cls     = CL_ILL;
        alu_op  = ALU_ADD;
        src_op  = 1'b0;
        rfwd_op = RFWD_ALU;
        unique case (instrCode[6:0])
            OP_TYPE_R: begin
                cls    = CL_R;
                alu_op = {instrCode[30], instrCode[14:12]};
            end
            OP_TYPE_I: begin
                cls    = CL_I;
                src_op = 1'b1;
                // instr[30] is immediate data except for SRAI.
                alu_op = ({instrCode[30], instrCode[14:12]} == ALU_SRAI)
                       ? ALU_SRAI : {1'b0, instrCode[14:12]};
            end
            OP_TYPE_L: begin
                cls     = CL_L;
                src_op  = 1'b1;
                rfwd_op = RFWD_LOAD;
            end
            OP_TYPE_S: begin
                cls    = CL_S;
                src_op = 1'b1;
            end
            OP_TYPE_B: begin
                cls    = CL_B;
                alu_op = {instrCode[30], instrCode[14:12]};
            end
            OP_TYPE_LU: begin
                cls     = CL_LU;
                rfwd_op = RFWD_LUI;
            end
            OP_TYPE_AU: begin
                cls     = CL_AU;
                rfwd_op = RFWD_AUIPC;
            end
            OP_TYPE_J: begin
                cls     = CL_J;
                rfwd_op = RFWD_PC4;
            end
            OP_TYPE_JL: begin
                cls     = CL_JL;
                rfwd_op = RFWD_PC4;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (cls == CL_ILL) ? TRAP : EXECUTE;
            EXECUTE: state_d = (cls == CL_L || cls == CL_S) ? MEM : FETCH;
            MEM: begin
                if (mem_done) begin
                    state_d = (cls == CL_L) ? WB : FETCH;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode state and opcode directly; reset forces the idle values
    // even in the cycle it is first sampled.
    always_comb begin
        pcEn          = 1'b0;
        irWe          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = ALU_CTRL_W'(ALU_ADD);
        aluSrcMuxSel  = 1'b0;
        busReq        = 1'b0;
        busWe         = 1'b0;
        RFWDSrcMuxSel = RFWD_SEL_W'(RFWD_ALU);
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: irWe = 1'b1;
                DECODE: begin
                    aluControl    = ALU_CTRL_W'(alu_op);
                    aluSrcMuxSel  = src_op;
                    RFWDSrcMuxSel = RFWD_SEL_W'(rfwd_op);
                end
                EXECUTE: begin
                    aluControl    = ALU_CTRL_W'(alu_op);
                    aluSrcMuxSel  = src_op;
                    RFWDSrcMuxSel = RFWD_SEL_W'(rfwd_op);
                    case (cls)
                        CL_R, CL_I, CL_LU, CL_AU: begin
                            regFileWe = 1'b1;
                            pcEn      = 1'b1;
                        end
                        CL_B: begin
                            branch = 1'b1;
                            pcEn   = 1'b1;
                        end
                        CL_J: begin
                            regFileWe = 1'b1;
                            pcEn      = 1'b1;
                            jal       = 1'b1;
                        end
                        CL_JL: begin
                            regFileWe = 1'b1;
                            pcEn      = 1'b1;
                            jal       = 1'b1;
                            jalr      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    busReq        = 1'b1;
                    aluSrcMuxSel  = 1'b1;
                    RFWDSrcMuxSel = RFWD_SEL_W'(rfwd_op);
                    busWe         = (cls == CL_S);
                    pcEn          = (cls == CL_S) && mem_done;
                end
                WB: begin
                    regFileWe     = 1'b1;
                    RFWDSrcMuxSel = RFWD_SEL_W'(RFWD_LOAD);
                    pcEn          = 1'b1;
                end
                TRAP:    illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
